// File: rtl/test_status_reporter_pkg.sv
// Shared constants for the test status reporter: register map, transmitter
// state encoding and the ASCII bytes that make up the report messages.
package test_status_reporter_pkg;

   localparam logic [7:0] OFF_TESTNUM = 8'h00;
   localparam logic [7:0] OFF_RESULT  = 8'h04;
   localparam logic [7:0] OFF_STATUS  = 8'h08;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] ASC_P      = 8'h50;
   localparam logic [7:0] ASC_A      = 8'h41;
   localparam logic [7:0] ASC_S      = 8'h53;
   localparam logic [7:0] ASC_F      = 8'h46;
   localparam logic [7:0] ASC_I      = 8'h49;
   localparam logic [7:0] ASC_L      = 8'h4C;
   localparam logic [7:0] ASC_NL     = 8'h0A;
   localparam logic [7:0] ASC_DIGIT0 = 8'h30;
   localparam logic [7:0] ASC_HEXA   = 8'h41;

   localparam int unsigned PASS_LEN = 5;
   localparam int unsigned FAIL_LEN = 7;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return ASC_DIGIT0 + {4'b0000, n};
      else
         return ASC_HEXA + {4'b0000, n - 4'd10};
   endfunction

   // "PASS\n" or "FAIL" + two hex digits + "\n", selected by position
   function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                              input logic       ok,
                                              input logic [7:0] num);
      logic [7:0] b;
      case (idx)
         3'd0:    b = ok ? ASC_P : ASC_F;
         3'd1:    b = ASC_A;
         3'd2:    b = ok ? ASC_S : ASC_I;
         3'd3:    b = ok ? ASC_S : ASC_L;
         3'd4:    b = ok ? ASC_NL : hex_ascii(num[7:4]);
         3'd5:    b = hex_ascii(num[3:0]);
         default: b = ASC_NL;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/test_status_reporter_uart_tx_byte.sv
// 8N1 byte transmitter; accepts the next byte in the last stop-bit cycle so
// consecutive bytes go out with no idle gap.
module uart_tx_byte
   import test_status_reporter_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       txd,
   output logic       busy
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   tx_state_t   state;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        bit_end;

   assign bit_end = (clk_cnt == LAST_CNT);
   assign ready   = (state == IDLE) || ((state == STOP) && bit_end);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               txd     <= 1'b1;
               if (valid) begin
                  shreg <= data;
                  txd   <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  txd     <= shreg[0];
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     txd     <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= shreg >> 1;
                     txd     <= shreg[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (valid) begin
                     shreg <= data;
                     txd   <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/test_status_reporter.sv
// Register window for a test program's result plus the sequencer that turns
// a completion report into a "PASS\n" / "FAILxx\n" UART message.
module test_status_reporter
   import test_status_reporter_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned ADDR_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              uart_txd,
   output logic              done,
   output logic              pass,
   output logic              busy
);

   logic [7:0]        testnum;
   logic [7:0]        snap;
   logic              drop_err;
   logic [2:0]        idx;
   logic [ADDR_W-1:0] base;
   logic              sel_testnum;
   logic              sel_result;
   logic              sel_status;
   logic              result_wr;
   logic              accept;
   logic              last_byte;
   logic              tx_valid;
   logic              tx_ready;
   logic [7:0]        tx_byte;
   logic              unused_bits;

   assign base        = {addr[ADDR_W-1:2], 2'b00};
   assign sel_testnum = (base == ADDR_W'(OFF_TESTNUM));
   assign sel_result  = (base == ADDR_W'(OFF_RESULT));
   assign sel_status  = (base == ADDR_W'(OFF_STATUS));
   assign unused_bits = ^{addr[1:0], wdata[31:8]};

   assign result_wr = we & sel_result & wdata[0];
   assign accept    = result_wr & ~busy;
   assign last_byte = (idx == (pass ? 3'(PASS_LEN - 1) : 3'(FAIL_LEN - 1)));

   // The first byte comes straight from the write data so the start bit
   // appears one cycle after the accepting edge.
   always_comb begin
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      if (accept) begin
         tx_valid = 1'b1;
         tx_byte  = report_byte(3'd0, wdata[1], testnum);
      end else if (busy && !last_byte) begin
         tx_valid = 1'b1;
         tx_byte  = report_byte(idx + 3'd1, pass, snap);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         testnum  <= '0;
         snap     <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         drop_err <= 1'b0;
         idx      <= '0;
      end else begin
         if (we && sel_testnum)
            testnum <= wdata[7:0];
         if (accept) begin
            done <= 1'b1;
            pass <= wdata[1];
            snap <= testnum;
         end else if (result_wr) begin
            drop_err <= 1'b1;
         end
         if (accept)
            idx <= '0;
         else if (tx_valid && tx_ready)
            idx <= idx + 3'd1;
         else if (!busy)
            idx <= '0;
      end
   end

   always_comb begin
      rdata = '0;
      if (sel_testnum)
         rdata = {24'b0, testnum};
      else if (sel_result)
         rdata = {30'b0, pass, done};
      else if (sel_status)
         rdata = {29'b0, drop_err, busy, done};
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .rst   (rst),
      .data  (tx_byte),
      .valid (tx_valid),
      .ready (tx_ready),
      .txd   (uart_txd),
      .busy  (busy)
   );

endmodule

// File: tb/tb_test_status_reporter.sv
// Bench for test_status_reporter: a bit-timeline model of the serial line and
// register file checked every cycle, plus a line decoder for literal messages.
module tb_test_status_reporter;

   localparam int CPB = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        we    = 1'b0;
   logic [3:0]  addr  = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        uart_txd;
   logic        done;
   logic        pass;
   logic        busy;

   int total = 0;
   int bad   = 0;

   test_status_reporter #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .uart_txd (uart_txd),
      .done     (done),
      .pass     (pass),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the line is a queue of per-cycle levels for the cycles to come.
   bit         mq[$];
   logic [7:0] mmsg[$];
   logic       m_txd  = 1'b1;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic       m_pass = 1'b0;
   logic       m_drop = 1'b0;
   logic [7:0] m_tn   = 8'h00;
   int         m_last_len = 0;

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return {24'b0, m_tn};
         2'd1:    return {30'b0, m_pass, m_done};
         2'd2:    return {29'b0, m_drop, m_busy, m_done};
         default: return 32'h0;
      endcase
   endfunction

   initial begin : model
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_txd  = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pass = 1'b0;
            m_drop = 1'b0;
            m_tn   = 8'h00;
         end else begin
            if (we && addr[3:2] == 2'd0) begin
               m_tn = wdata[7:0];
            end else if (we && addr[3:2] == 2'd1 && wdata[0]) begin
               if (m_busy) begin
                  m_drop = 1'b1;
               end else begin
                  m_done = 1'b1;
                  m_pass = wdata[1];
                  mmsg.delete();
                  if (wdata[1]) begin
                     mmsg.push_back(8'h50); mmsg.push_back(8'h41);
                     mmsg.push_back(8'h53); mmsg.push_back(8'h53);
                  end else begin
                     mmsg.push_back(8'h46); mmsg.push_back(8'h41);
                     mmsg.push_back(8'h49); mmsg.push_back(8'h4C);
                     mmsg.push_back(hexc(m_tn[7:4]));
                     mmsg.push_back(hexc(m_tn[3:0]));
                  end
                  mmsg.push_back(8'h0A);
                  foreach (mmsg[j]) begin
                     repeat (CPB) mq.push_back(1'b0);
                     for (int k = 0; k < 8; k++)
                        repeat (CPB) mq.push_back(mmsg[j][k]);
                     repeat (CPB) mq.push_back(1'b1);
                  end
                  m_last_len = mq.size();
               end
            end
            if (mq.size() > 0) begin
               m_txd  = mq.pop_front();
               m_busy = 1'b1;
            end else begin
               m_txd  = 1'b1;
               m_busy = 1'b0;
            end
         end
      end
   end

   int   edges = 0;
   logic prev_txd = 1'b1;

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("txd",   {31'b0, uart_txd}, {31'b0, m_txd});
         chk("busy",  {31'b0, busy},     {31'b0, m_busy});
         chk("done",  {31'b0, done},     {31'b0, m_done});
         chk("pass",  {31'b0, pass},     {31'b0, m_pass});
         chk("rdata", rdata, exp_rdata(addr));
         if (uart_txd !== prev_txd) edges++;
         prev_txd = uart_txd;
      end
   end

   // Independent 8N1 decoder sampling one cycle into each bit
   logic [7:0] dq[$];

   initial begin : decoder
      logic [7:0] b;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (uart_txd === 1'b0) begin
            repeat (CPB + 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = uart_txd;
               if (i < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            if (uart_txd === 1'b1) dq.push_back(b);
         end
      end
   end

   logic [7:0] exp_pass [5] = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
   logic [7:0] exp_fail [7] = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h32, 8'h42, 8'h0A};

   task automatic check_dec(input string tag, input bit use_pass);
      int n;
      logic [7:0] e;
      n = use_pass ? 5 : 7;
      chk({tag, "_len"}, dq.size(), n);
      for (int i = 0; i < n && i < dq.size(); i++) begin
         if (use_pass) e = exp_pass[i];
         else          e = exp_fail[i];
         chk($sformatf("%s_byte%0d", tag, i), {24'b0, dq[i]}, {24'b0, e});
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk); #1;
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'h0);
   endtask

   initial begin : main
      repeat (2) @(negedge clk);
      #1;
      chk("rst_txd",  {31'b0, uart_txd}, 32'h1);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_pass", {31'b0, pass}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      addr = 4'h8; #1;
      chk("rst_status", rdata, 32'h0);
      addr = 4'h0; #1;
      chk("rst_testnum", rdata, 32'h0);

      // PASS report accepted on the very first edge after reset release
      @(negedge clk); #1;
      rst = 1'b0; we = 1'b1; addr = 4'h4; wdata = 32'h3;
      @(posedge clk); #1;
      we = 1'b0;
      chk("pass_len", m_last_len, 200);
      repeat (200) @(posedge clk);
      #1;
      chk("pass_busy_end", {31'b0, busy}, 32'h0);
      chk("pass_done", {31'b0, done}, 32'h1);
      chk("pass_pass", {31'b0, pass}, 32'h1);
      check_dec("pass_msg", 1'b1);

      // FAIL report with test number 0x2B
      dq.delete();
      wr(4'h0, 32'h2B);
      wr(4'h4, 32'h1);
      chk("fail_len", m_last_len, 280);
      repeat (280) @(posedge clk);
      #1;
      chk("fail_busy_end", {31'b0, busy}, 32'h0);
      chk("fail_pass", {31'b0, pass}, 32'h0);
      check_dec("fail_msg", 1'b0);

      // Writes during a report: snapshot holds, second result dropped
      dq.delete();
      wr(4'h4, 32'h1);
      repeat (50) @(posedge clk);
      wr(4'h0, 32'hFF);
      wr(4'h4, 32'h3);
      chk("drop_pass", {31'b0, pass}, 32'h0);
      addr = 4'h8; #1;
      chk("drop_status_bit2", {31'b0, rdata[2]}, 32'h1);
      wait_idle(400);
      repeat (2) @(posedge clk);
      check_dec("drop_msg", 1'b0);
      addr = 4'h0; #1;
      chk("drop_testnum", rdata, 32'hFF);

      // Reset in the middle of the data bits of byte 2
      wr(4'h4, 32'h1);
      repeat (90) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1; #1;
      chk("abort_txd",  {31'b0, uart_txd}, 32'h1);
      chk("abort_done", {31'b0, done}, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      @(negedge clk); #1;
      rst = 1'b0;
      edges = 0;
      repeat (100) @(posedge clk);
      #1;
      chk("abort_edges", edges, 0);
      chk("abort_done_after", {31'b0, done}, 32'h0);

      // Result write without the done bit, and an unmapped offset
      edges = 0;
      wr(4'h4, 32'h2);
      repeat (50) @(posedge clk);
      #1;
      chk("nodone_done", {31'b0, done}, 32'h0);
      chk("nodone_edges", edges, 0);
      addr = 4'hC; #1;
      chk("unmapped_rd", rdata, 32'h0);
      wr(4'hC, 32'hFFFF_FFFF);
      addr = 4'h0; #1;
      chk("unmapped_wr", rdata, 32'h0);

      // Randomized traffic, occasional reset pulses
      repeat (4000) begin
         @(negedge clk); #1;
         addr  = 4'($urandom_range(0, 15));
         wdata = $urandom;
         we    = ($urandom_range(0, 24) == 0);
         rst   = ($urandom_range(0, 1999) == 0);
      end
      @(negedge clk); #1;
      we  = 1'b0;
      rst = 1'b0;
      wait_idle(400);
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/test_status_reporter.md
TEST_STATUS_REPORTER -- requirements
Module: test_status_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter ADDR_W, default 4, width of the byte address into the register window.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port we  input  1  register write strobe, one-cycle, sampled on clk.
REQ-006 SHALL have port addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  combinational read data for addr.
REQ-009 SHALL have port uart_txd  output  1  serial report line, idle high.
REQ-010 SHALL have port done  output  1  sticky: test program reported completion.
REQ-011 SHALL have port pass  output  1  sticky: result of the completion report.
REQ-012 SHALL have port busy  output  1  report transmission in progress.

Function
REQ-013 SHALL map registers: 0x0 TESTNUM (RW, bits [7:0]), 0x4 RESULT (W: bit0 done, bit1 pass; R: {30'b0, pass, done}), 0x8 STATUS (R: {29'b0, drop_err, busy, done}); all other offsets read 0, writes ignored.
REQ-014 SHALL, on we to RESULT with wdata[0]=1 while busy=0, set done=1 and pass=wdata[1] in the next cycle, snapshot TESTNUM, and start a report.
REQ-015 SHALL ignore a RESULT write with wdata[0]=0.
REQ-016 SHALL, on a RESULT write with wdata[0]=1 while busy=1, leave done, pass and the report unchanged and set sticky drop_err=1.
REQ-017 SHALL send report "PASS\n" (5 bytes) when pass=1, else "FAIL" + two uppercase ASCII hex digits of the snapshot (high nibble first) + "\n" (7 bytes).
REQ-018 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1, each held exactly CLKS_PER_BIT cycles; bytes back-to-back with no idle gap.
REQ-019 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on an accepted report; START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->IDLE.
REQ-020 SHALL drive uart_txd low in the first cycle after the accepting write edge (latency 1).
REQ-021 SHALL hold busy=1 from the cycle uart_txd first goes low through the last stop-bit cycle, and busy=0 in IDLE.
REQ-022 SHALL allow TESTNUM writes at any time; writes during a report SHALL NOT alter bytes in flight.
REQ-023 SHALL wrap the bit counter 0..7 and the byte index 0..6 without overflow into unused values.

Reset
REQ-024 SHALL, on rst=1, immediately force uart_txd=1, done=0, pass=0, busy=0, drop_err=0, TESTNUM=0, FSM=IDLE, all counters 0.
REQ-025 SHALL abort an in-flight report on reset with no partial byte resumed after release.
REQ-026 SHALL accept a RESULT write in the first clk edge after rst deasserts.

Structure
REQ-027 SHALL place register offsets, FSM state encoding, and ASCII constants ('P','A','S','F','I','L','\n', hex digit base values) in a shared package.
REQ-028 SHALL instantiate a single sub-module uart_tx_byte (byte-in/valid/ready, txd-out), with the message sequencer in the top module.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL check: write RESULT=0x3 -> done=1, pass=1, line decodes 0x50 0x41 0x53 0x53 0x0A, busy low after 200 cycles.
REQ-030 SHALL check: write TESTNUM=0x2B then RESULT=0x1 -> pass=0, line decodes "FAIL2B\n" (0x46 0x41 0x49 0x4C 0x32 0x42 0x0A) in 280 cycles.
REQ-031 SHALL check: during a FAIL report write TESTNUM=0xFF and RESULT=0x3 -> transmitted digits unchanged, pass stays 0, STATUS bit2=1.
REQ-032 SHALL check: assert rst for 1 cycle mid-DATA of byte 2 -> uart_txd=1 in the same cycle, done=0, no further edges on the line.
REQ-033 SHALL check: write RESULT=0x2 -> no transmission, done=0; read of offset 0xC -> rdata=0.
REQ-034 SHALL check: every bit period of uart_txd measured exactly 4 cycles; uart_txd=1 whenever busy=0.
